opsum_drain_arb: RTL and testbench
==================================

# opsum_drain_arb

Round-robin drain controller for the conv unit's per-column output partial-sum FIFOs. Once a tile is started, it scans the NUM_COL opsum FIFOs and pops at most one column per cycle. Each popped word goes into a 2-entry output buffer and leaves on a single valid/ready stream tagged with its column index. The block signals `done` when the programmed number of words has been delivered downstream. It sits between the conv unit's `opsum_pop_en`/`opsum_fifo_empty`/`opsum_pop_data` ports and the output write-back path.

## Interface
- `NUM_COL`, 32, number of opsum FIFO columns (power of 2).
- `DATA_W`, 32, opsum word width.
- `CNT_W`, 16, width of the per-tile word counters.
- `COL_W`, $clog2(NUM_COL), column tag width.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a tile drain; ignored while `busy`=1.
- `expected_cnt`  in  CNT_W  number of words to drain for this tile; sampled when `start` is accepted.
- `opsum_fifo_empty`  in  NUM_COL  per-column empty flag, updated at the same edge as the pop.
- `opsum_pop_data`  in  NUM_COL x DATA_W  per-column read data, valid in the cycle after its `opsum_pop_en` bit was high.
- `opsum_pop_en`  out  NUM_COL  one-hot (or zero) pop strobe, combinational from registered state.
- `out_valid`  out  1  output word available.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  DATA_W  head word of the buffer.
- `out_col`  out  COL_W  source column of `out_data`.
- `busy`  out  1  a tile drain is in progress.
- `done`  out  1  single-cycle pulse when the last word is accepted downstream.

## Operation
- States:
  - IDLE: waits for `start`; latches `expected_cnt`; clears `issued_cnt` and `accepted_cnt`; moves to DRAIN.
  - DRAIN: issues pops; moves to FINISH when `accepted_cnt` reaches `expected_cnt`.
  - FINISH: asserts `done` for one cycle; returns to IDLE.
- If `expected_cnt`=0, the path is IDLE→DRAIN→FINISH with no pops.
- Arbitration:
  - `ptr` holds the column granted last; its reset value is NUM_COL-1.
  - The candidate is the first column c in the order ptr+1, ptr+2, … (mod NUM_COL) with `opsum_fifo_empty[c]`=0.
  - `ptr` updates to c only when the pop is actually issued.
- Pop issue condition, all in DRAIN:
  - a candidate exists,
  - `issued_cnt` < `expected_cnt`,
  - `occ` + `inflight` − (`out_valid` && `out_ready`) < 2.
- When issued: exactly one bit of `opsum_pop_en` is high, `issued_cnt` increments, and `inflight` is set for the next cycle together with the captured column tag.
- Capture: in a cycle with `inflight`=1, the selected `opsum_pop_data[tag]` and its tag are written into the 2-entry FIFO-ordered buffer. `occ` takes values 0..2.
- Output: `out_valid` = (`occ`≠0). On `out_valid` && `out_ready`, the head is dequeued and `accepted_cnt` increments.
- A capture and a dequeue in the same cycle leave `occ` unchanged. Word order is preserved.
- Counters are CNT_W wide and never wrap, because issue stops at `expected_cnt`.
- `busy` = 1 in DRAIN and FINISH.

## Timing
- Reset values: `opsum_pop_en`=0, `out_valid`=0, `out_data`=0, `out_col`=0, `busy`=0, `done`=0, `occ`=0, `inflight`=0, `ptr`=NUM_COL-1.
- During `rst`=1, `opsum_pop_en` is forced to 0 in that same cycle. Reset mid-drain discards buffered and in-flight words and clears all counters.
- Latency for a non-empty column with `out_ready`=1:
  - `start` at cycle T,
  - `busy` and the first `opsum_pop_en` at T+1,
  - captured at the end of T+2,
  - `out_valid` at T+3.
- Sustained throughput: 1 word/cycle while `out_ready`=1 and some FIFO is non-empty.
- With `out_ready`=0: at most 2 words are outstanding (`occ` + `inflight` ≤ 2), and pops stop.
- `done` rises one cycle after the cycle in which the final word is accepted. `busy` falls one cycle after `done`.
- A `start` arriving during `busy` or FINISH is dropped. A `start` is accepted in the first IDLE cycle.

## Test plan
- Reset: hold `rst` for 2 cycles with all FIFOs non-empty → `opsum_pop_en`=0 during reset and all outputs at their reset values. Then `start` with `expected_cnt`=0 → `done` at T+2 with no pops.
- Round-robin fairness: columns 0, 5 and 31 each hold 2 words; `expected_cnt`=6; `out_ready`=1 → `out_col` sequence 0,5,31,0,5,31 and `done` after the 6th acceptance.
- Throughput: column 3 holds 8 words; `out_ready`=1 → 8 consecutive `out_valid` cycles starting at T+3, then one `done` pulse.
- Backpressure: column 7 holds 4 words; `out_ready`=0 for 10 cycles → exactly 2 pops and `out_valid` held with the first word. After `out_ready` is released → remaining words arrive in order with values unchanged.
- Idle gaps: all FIFOs empty for 5 cycles mid-tile → no pops and `busy` stays 1. A word pushed into column 12 is then drained, and `done` fires when `accepted_cnt` = `expected_cnt`.
- Mid-drain reset: `rst` asserted after 3 of 10 words → `opsum_pop_en`=0 and `out_valid`=0 on the following cycle. A fresh `start` then works normally.

Source files
------------

// File: rtl/opsum_drain_arb.sv
// opsum_drain_arb: round-robin drain of per-column opsum FIFOs into one tagged valid/ready stream
module opsum_drain_arb #(
  parameter int NUM_COL = 32,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16,
  parameter int COL_W   = $clog2(NUM_COL)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [CNT_W-1:0]                expected_cnt,
  input  logic [NUM_COL-1:0]              opsum_fifo_empty,
  input  logic [NUM_COL-1:0][DATA_W-1:0]  opsum_pop_data,
  output logic [NUM_COL-1:0]              opsum_pop_en,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_W-1:0]               out_data,
  output logic [COL_W-1:0]                out_col,
  output logic                            busy,
  output logic                            done
);
  typedef enum logic [1:0] {IDLE, DRAIN, FINISH} state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_exp, r_iss, r_acc, w_acc_next;
  logic [COL_W-1:0] r_ptr, r_tag, w_cand;
  logic [1:0][DATA_W-1:0] r_buf_d;
  logic [1:0][COL_W-1:0] r_buf_c;
  logic [1:0] r_occ, w_load;
  logic r_inflight, w_has, w_pop, w_deq, w_wr;
  assign out_valid  = r_occ != 2'd0;
  assign out_data   = r_buf_d[0];
  assign out_col    = r_buf_c[0];
  assign w_deq      = out_valid && out_ready;
  assign w_acc_next = r_acc + CNT_W'(w_deq);
  assign w_load     = r_occ + 2'(r_inflight) - 2'(w_deq);
  assign w_wr       = 1'(r_occ - 2'(w_deq));
  assign w_pop      = r_state == DRAIN && w_has && r_iss < r_exp && w_load < 2'd2 && !rst;
  assign opsum_pop_en = w_pop ? (NUM_COL'(1) << w_cand) : '0;
  // first non-empty column after the last grant; later-scanned hits are overwritten by nearer ones
  always_comb begin
    w_has  = 1'b0;
    w_cand = r_ptr;
    for (int i = NUM_COL; i >= 1; i--)
      if (!opsum_fifo_empty[r_ptr + COL_W'(i)]) begin
        w_has  = 1'b1;
        w_cand = r_ptr + COL_W'(i);
      end
  end
  // tile sequencing: finish as soon as the final acceptance lands, so done follows it by one cycle
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE)  ? (start ? DRAIN : IDLE) :
             (r_state == DRAIN) ? ((w_acc_next == r_exp) ? FINISH : DRAIN) : IDLE;
    busy = r_state != IDLE;
    done = r_state == FINISH;
  end
  // state register
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  // counters, arbiter pointer, in-flight tag and the 2-entry ordered output buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp      <= '0;
      r_iss      <= '0;
      r_acc      <= '0;
      r_ptr      <= COL_W'(NUM_COL - 1);
      r_tag      <= '0;
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_buf_d    <= '0;
      r_buf_c    <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_exp <= expected_cnt;
        r_iss <= '0;
        r_acc <= '0;
      end else begin
        r_iss <= r_iss + CNT_W'(w_pop);
        r_acc <= w_acc_next;
      end
      r_inflight <= w_pop;
      if (w_pop) begin
        r_tag <= w_cand;
        r_ptr <= w_cand;
      end
      r_occ <= w_load;
      if (w_deq) begin
        r_buf_d[0] <= r_buf_d[1];
        r_buf_c[0] <= r_buf_c[1];
      end
      if (r_inflight) begin
        r_buf_d[w_wr] <= opsum_pop_data[r_tag];
        r_buf_c[w_wr] <= r_tag;
      end
    end
  end
endmodule

// File: tb/tb_opsum_drain_arb.sv
// tb_opsum_drain_arb: directed and randomized checks of opsum_drain_arb against a queue-based reference
module tb_opsum_drain_arb;
  localparam int NC = 32, DW = 32, CW = 16, COLW = 5;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic [CW-1:0] expected_cnt = '0;
  logic [NC-1:0] fifo_empty = '1;
  logic [NC-1:0][DW-1:0] pop_data = '0;
  logic [NC-1:0] pop_en;
  logic out_valid, busy, done;
  logic [DW-1:0] out_data;
  logic [COLW-1:0] out_col;
  int n_tests = 0, n_fail = 0;
  logic [DW-1:0] mem [NC][256];
  int hd [NC];
  int tl [NC];
  logic [DW-1:0] exq_d [$];
  int exq_c [$];
  int exq_t [$];
  int m_ptr = NC - 1, m_exp = 0, m_iss = 0, m_acc = 0, m_done_cyc = -1, cyc_n = 0, pend = -1;
  bit m_busy = 1'b0, m_known = 1'b0;
  int n_done, n_pops, first_v, n_v, last_v, last_done;
  int acc_cols [$];
  int rr_exp [6] = '{0, 5, 31, 0, 5, 31};
  logic s_valid, s_busy, s_done;
  logic [NC-1:0] s_pop;
  logic [DW-1:0] s_data;
  logic [COLW-1:0] s_col;

  always #5 clk = ~clk;

  opsum_drain_arb #(.NUM_COL(NC), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .expected_cnt(expected_cnt),
    .opsum_fifo_empty(fifo_empty), .opsum_pop_data(pop_data), .opsum_pop_en(pop_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_col(out_col),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void upd_empty();
    for (int c = 0; c < NC; c++) fifo_empty[c] = (hd[c] == tl[c]);
  endfunction

  task automatic push(input int c, input logic [DW-1:0] v);
    mem[c][tl[c] & 255] = v;
    tl[c]++;
    upd_empty();
  endtask

  task automatic flush();
    for (int c = 0; c < NC; c++) hd[c] = tl[c];
    upd_empty();
  endtask

  task automatic clr_obs();
    n_done = 0; n_pops = 0; first_v = -1; n_v = 0; last_v = -1; last_done = -1;
    acc_cols.delete();
  endtask

  // one clock: sample at negedge, compare with the reference, advance the reference, apply FIFO pops after the edge
  task automatic cyc();
    bit ev, dq, ex_pop, nb;
    int cand;
    logic [NC-1:0] ep;
    @(negedge clk);
    s_valid = out_valid; s_busy = busy; s_done = done; s_pop = pop_en; s_data = out_data; s_col = out_col;
    ev = exq_d.size() > 0 && exq_t[0] + 2 <= cyc_n;
    dq = ev && out_ready;
    cand = -1;
    for (int k = 1; k <= NC; k++) begin
      int c;
      c = (m_ptr + k) % NC;
      if (hd[c] != tl[c]) begin
        cand = c;
        break;
      end
    end
    ex_pop = !rst && m_busy && cand >= 0 && m_iss < m_exp && (m_iss - m_acc - int'(dq)) < 2;
    ep = '0;
    if (ex_pop) ep[cand] = 1'b1;
    if (rst || m_known) chk("pop_en", s_pop, ep);
    if (m_known) begin
      chk("out_valid", s_valid, ev);
      chk("busy", s_busy, m_busy);
      chk("done", s_done, m_busy && cyc_n == m_done_cyc);
    end
    if (s_pop != '0) n_pops++;
    if (s_done) begin n_done++; last_done = cyc_n; end
    if (s_valid) begin
      if (first_v < 0) first_v = cyc_n;
      last_v = cyc_n;
      n_v++;
    end
    if (dq) begin
      chk("out_data", s_data, exq_d[0]);
      chk("out_col", s_col, exq_c[0]);
      acc_cols.push_back(int'(s_col));
      void'(exq_d.pop_front()); void'(exq_c.pop_front()); void'(exq_t.pop_front());
      m_acc++;
    end
    if (ex_pop) begin
      m_ptr = cand;
      m_iss++;
      exq_d.push_back(mem[cand][hd[cand] & 255]);
      exq_c.push_back(cand);
      exq_t.push_back(cyc_n);
      pend = cand;
    end
    nb = m_busy;
    if (m_busy && cyc_n == m_done_cyc) begin
      nb = 1'b0;
      m_done_cyc = -1;
    end else if (m_busy && m_done_cyc < 0 && m_acc == m_exp) m_done_cyc = cyc_n + 1;
    if (!m_busy && start) begin
      nb = 1'b1; m_exp = int'(expected_cnt); m_iss = 0; m_acc = 0;
    end
    if (rst) begin
      nb = 1'b0; m_done_cyc = -1; m_ptr = NC - 1;
      exq_d.delete(); exq_c.delete(); exq_t.delete();
      m_known = 1'b1;
    end
    m_busy = nb;
    @(posedge clk);
    #1;
    if (pend >= 0) begin
      pop_data[pend] = mem[pend][hd[pend] & 255];
      hd[pend]++;
      pend = -1;
      upd_empty();
    end
    cyc_n++;
  endtask

  task automatic begin_tile(input int cnt);
    start = 1'b1;
    expected_cnt = CW'(cnt);
    cyc();
    start = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic drain(input int maxc);
    int i;
    i = 0;
    while (m_busy && i < maxc) begin
      cyc();
      i++;
    end
    chk("drain_timeout", m_busy, 0);
  endtask

  initial begin
    int t0, i, j, tot;
    // reset with every column holding a word, then a zero-length tile
    for (int c = 0; c < NC; c++) push(c, 32'hA000_0000 + DW'(c));
    clr_obs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk("rst_pops", n_pops, 0);
    chk("rst_out_data", s_data, 0);
    chk("rst_out_col", s_col, 0);
    chk("rst_valid", s_valid, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_done", s_done, 0);
    clr_obs();
    t0 = cyc_n;
    begin_tile(0);
    run(3);
    chk("zero_pops", n_pops, 0);
    chk("zero_done_cnt", n_done, 1);
    chk("zero_done_cyc", last_done - t0, 2);
    chk("zero_busy_after", s_busy, 0);
    flush();
    // round-robin fairness over columns 0, 5, 31
    out_ready = 1'b1;
    clr_obs();
    for (int k = 0; k < 2; k++) begin
      push(0, 32'h0000_0100 + DW'(k));
      push(5, 32'h0000_0500 + DW'(k));
      push(31, 32'h0000_3100 + DW'(k));
    end
    begin_tile(6);
    drain(60);
    chk("rr_count", acc_cols.size(), 6);
    for (int k = 0; k < 6 && k < acc_cols.size(); k++) chk("rr_col", acc_cols[k], rr_exp[k]);
    chk("rr_done", n_done, 1);
    // throughput from a single column
    clr_obs();
    for (int k = 0; k < 8; k++) push(3, 32'h3300_0000 + DW'(k));
    t0 = cyc_n;
    begin_tile(8);
    drain(60);
    chk("tp_first_valid", first_v - t0, 3);
    chk("tp_valid_cnt", n_v, 8);
    chk("tp_span", last_v - first_v, 7);
    chk("tp_done", n_done, 1);
    chk("tp_done_cyc", last_done - last_v, 1);
    // backpressure holds two outstanding words
    clr_obs();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) push(7, 32'h7700_0000 + DW'(k));
    begin_tile(4);
    run(10);
    chk("bp_pops", n_pops, 2);
    chk("bp_valid", s_valid, 1);
    chk("bp_head", s_data, 32'h7700_0000);
    chk("bp_col", s_col, 7);
    out_ready = 1'b1;
    drain(60);
    chk("bp_acc", acc_cols.size(), 4);
    chk("bp_done", n_done, 1);
    // idle gap mid-tile, then a late word in column 12
    clr_obs();
    push(20, 32'h2000_0001);
    push(20, 32'h2000_0002);
    begin_tile(3);
    run(8);
    clr_obs();
    run(5);
    chk("gap_pops", n_pops, 0);
    chk("gap_busy", s_busy, 1);
    push(12, 32'h1200_0C0C);
    drain(60);
    chk("gap_done", n_done, 1);
    chk("gap_col", acc_cols.size() > 0 ? acc_cols[acc_cols.size() - 1] : -1, 12);
    // reset after 3 of 10 words, then a fresh tile
    clr_obs();
    for (int k = 0; k < 10; k++) push(9, 32'h9900_0000 + DW'(k));
    begin_tile(10);
    i = 0;
    while (acc_cols.size() < 3 && i < 50) begin
      cyc();
      i++;
    end
    chk("mr_acc3", acc_cols.size(), 3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("mr_pop", s_pop, 0);
    chk("mr_valid", s_valid, 0);
    chk("mr_busy", s_busy, 0);
    flush();
    clr_obs();
    for (int k = 0; k < 3; k++) push(1, 32'h0101_0000 + DW'(k));
    begin_tile(3);
    drain(60);
    chk("mr_restart_done", n_done, 1);
    chk("mr_restart_cnt", acc_cols.size(), 3);
    // randomized tiles with random backpressure, late pushes and dropped starts
    for (int t = 0; t < 10; t++) begin
      flush();
      clr_obs();
      tot = 0;
      for (int k = 0; k < 24; k++)
        if ($urandom_range(0, 1) == 1) begin
          push(int'($urandom_range(0, NC - 1)), $urandom);
          tot++;
        end
      begin_tile(int'($urandom_range(0, tot)));
      j = 0;
      while (m_busy && j < 2000) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) push(int'($urandom_range(0, NC - 1)), $urandom);
        if ($urandom_range(0, 15) == 0) begin
          start = 1'b1;
          expected_cnt = CW'($urandom);
        end
        cyc();
        start = 1'b0;
        j++;
      end
      chk("rnd_idle", m_busy, 0);
      chk("rnd_done", n_done, 1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
